// File: rtl/alu_serial_unit_if.sv
// Request/response bundle for the serial ALU: issue-side request with operands,
// writeback-side response with result and flags.
interface alu_serial_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  shamt;
    logic [5:0]  ALUFunc;
    logic        Signed;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] Result;
    logic        Zero;
    logic        Overflow;
    logic        Negative;

    modport master (
        output req_valid, A, B, shamt, ALUFunc, Signed, resp_ready,
        input  req_ready, resp_valid, Result, Zero, Overflow, Negative
    );

    modport slave (
        input  req_valid, A, B, shamt, ALUFunc, Signed, resp_ready,
        output req_ready, resp_valid, Result, Zero, Overflow, Negative
    );
endinterface

// File: rtl/alu_serial_unit.sv
// Sequential ALU execution unit: single-cycle arith/logic/compare, bit-serial
// shifts (one position per cycle), registered result and flags.
module alu_serial_unit (
    input  logic             clk,
    input  logic             reset,
    alu_serial_unit_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_t;

    localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001;
    localparam logic [5:0] OP_AND = 6'b011000, OP_OR  = 6'b011110, OP_XOR = 6'b010110;
    localparam logic [5:0] OP_NOR = 6'b010001, OP_A   = 6'b011010;
    localparam logic [5:0] OP_SLL = 6'b100000, OP_SRL = 6'b100001, OP_SRA = 6'b100011;
    localparam logic [5:0] OP_EQ  = 6'b110011, OP_NEQ = 6'b110001, OP_LT  = 6'b110101;
    localparam logic [5:0] OP_LEZ = 6'b111101, OP_GEZ = 6'b111001, OP_GTZ = 6'b111111;

    // Packs {result[31:0], overflow, negative} for every single-cycle operation.
    function automatic logic [33:0] alu_eval(input logic [31:0] a, input logic [31:0] b,
                                             input logic [5:0] func, input logic sgn);
        logic [32:0] sum;
        logic [32:0] diff;
        logic [31:0] res;
        logic        ov;
        logic        neg;
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        case (func)
            OP_ADD: begin
                res = sum[31:0];
                ov  = sgn ? ((a[31] == b[31]) && (res[31] != a[31])) : sum[32];
                neg = sgn ? (res[31] ^ ov) : 1'b0;
            end
            OP_SUB: begin
                res = diff[31:0];
                ov  = sgn ? ((a[31] != b[31]) && (res[31] != a[31])) : diff[32];
                neg = sgn ? (res[31] ^ ov) : diff[32];
            end
            OP_AND:  begin res = a & b;    ov = 1'b0; neg = res[31]; end
            OP_OR:   begin res = a | b;    ov = 1'b0; neg = res[31]; end
            OP_XOR:  begin res = a ^ b;    ov = 1'b0; neg = res[31]; end
            OP_NOR:  begin res = ~(a | b); ov = 1'b0; neg = res[31]; end
            OP_A:    begin res = a;        ov = 1'b0; neg = res[31]; end
            OP_EQ:   begin res = {31'd0, (a == b)}; ov = 1'b0; neg = 1'b0; end
            OP_NEQ:  begin res = {31'd0, (a != b)}; ov = 1'b0; neg = 1'b0; end
            OP_LT:   begin
                res = {31'd0, (sgn ? ($signed(a) < $signed(b)) : (a < b))};
                ov  = 1'b0;
                neg = 1'b0;
            end
            OP_LEZ:  begin res = {31'd0, (a[31] | (a == 32'd0))};   ov = 1'b0; neg = 1'b0; end
            OP_GEZ:  begin res = {31'd0, ~a[31]};                   ov = 1'b0; neg = 1'b0; end
            OP_GTZ:  begin res = {31'd0, (~a[31] & (a != 32'd0))};  ov = 1'b0; neg = 1'b0; end
            default: begin res = 32'd0; ov = 1'b0; neg = 1'b0; end
        endcase
        return {res, ov, neg};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [5:0]  func_q, func_d;
    logic        fill_q, fill_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        ovf_q, ovf_d;
    logic        neg_q, neg_d;
    logic        resp_valid_q, resp_valid_d;
    logic        req_ready_q, req_ready_d;

    logic        accept_s;
    logic        resp_hs_s;
    logic        is_shift_s;
    logic [31:0] shift_s;
    logic [33:0] eval_s;

    assign accept_s   = bus.req_valid && req_ready_q;
    assign resp_hs_s  = resp_valid_q && bus.resp_ready;
    assign is_shift_s = (bus.ALUFunc == OP_SLL) || (bus.ALUFunc == OP_SRL) || (bus.ALUFunc == OP_SRA);
    assign eval_s     = alu_eval(bus.A, bus.B, bus.ALUFunc, bus.Signed);

    // Single-position shifter; fill_q holds the captured B[31] for SRA.
    always_comb begin
        case (func_q)
            OP_SLL:  shift_s = {work_q[30:0], 1'b0};
            OP_SRA:  shift_s = {fill_q, work_q[31:1]};
            default: shift_s = {1'b0, work_q[31:1]};
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a zero-length shift skips SHIFT to keep 1-cycle latency.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = (is_shift_s && (bus.shamt != 5'd0)) ? ST_SHIFT : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: state_d = (cnt_q <= 5'd1) ? ST_DONE : ST_SHIFT;
            ST_DONE:  state_d = resp_hs_s ? ST_IDLE : ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of datapath and output registers; outputs hold outside loads.
    always_comb begin
        work_d       = work_q;
        cnt_d        = cnt_q;
        func_d       = func_q;
        fill_d       = fill_q;
        result_d     = result_q;
        zero_d       = zero_q;
        ovf_d        = ovf_q;
        neg_d        = neg_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    work_d = bus.B;
                    cnt_d  = bus.shamt;
                    func_d = bus.ALUFunc;
                    fill_d = bus.B[31];
                    if (!is_shift_s) begin
                        result_d     = eval_s[33:2];
                        ovf_d        = eval_s[1];
                        neg_d        = eval_s[0];
                        zero_d       = (eval_s[33:2] == 32'd0);
                        resp_valid_d = 1'b1;
                    end else if (bus.shamt == 5'd0) begin
                        result_d     = bus.B;
                        ovf_d        = 1'b0;
                        neg_d        = bus.B[31];
                        zero_d       = (bus.B == 32'd0);
                        resp_valid_d = 1'b1;
                    end else begin
                        resp_valid_d = 1'b0;
                    end
                end else begin
                    resp_valid_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                work_d = shift_s;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q <= 5'd1) begin
                    result_d     = shift_s;
                    ovf_d        = 1'b0;
                    neg_d        = shift_s[31];
                    zero_d       = (shift_s == 32'd0);
                    resp_valid_d = 1'b1;
                end else begin
                    resp_valid_d = 1'b0;
                end
            end
            ST_DONE: begin
                if (resp_hs_s) begin
                    resp_valid_d = 1'b0;
                end else begin
                    resp_valid_d = 1'b1;
                end
            end
            default: resp_valid_d = 1'b0;
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work_q       <= 32'd0;
            cnt_q        <= 5'd0;
            func_q       <= 6'd0;
            fill_q       <= 1'b0;
            result_q     <= 32'd0;
            zero_q       <= 1'b0;
            ovf_q        <= 1'b0;
            neg_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b0;
        end else begin
            work_q       <= work_d;
            cnt_q        <= cnt_d;
            func_q       <= func_d;
            fill_q       <= fill_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            ovf_q        <= ovf_d;
            neg_q        <= neg_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.Result     = result_q;
    assign bus.Zero       = zero_q;
    assign bus.Overflow   = ovf_q;
    assign bus.Negative   = neg_q;
endmodule

// File: tb/tb_alu_serial_unit.sv
// Directed self-checking bench for alu_serial_unit: logic, shifts, arithmetic,
// compares, backpressure, operand isolation and mid-operation reset.
module tb_alu_serial_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    alu_serial_unit_if bus ();

    alu_serial_unit dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, measure accept-to-resp_valid cycles, then take the response.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                          input logic [5:0] f, input logic s, output int lat,
                          output logic [31:0] r, output logic [2:0] zon);
        int w;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.shamt = sh; bus.ALUFunc = f; bus.Signed = s;
        bus.req_valid = 1'b1;
        w = 0;
        while (!bus.req_ready && w < 50) begin @(negedge clk); w++; end
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 100) begin @(negedge clk); lat++; end
        r   = bus.Result;
        zon = {bus.Zero, bus.Overflow, bus.Negative};
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.resp_valid, bus.Result, bus.Zero, bus.Overflow, bus.Negative} !== 37'd0)
            $display("FAIL reset_outputs got rdy=%b vld=%b res=%h zon=%b%b%b exp all 0",
                     bus.req_ready, bus.resp_valid, bus.Result, bus.Zero, bus.Overflow, bus.Negative);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.resp_valid} !== 2'b10)
            $display("FAIL reset_release got rdy/vld=%b%b exp 10", bus.req_ready, bus.resp_valid);
        else n_pass++;
    endtask

    task automatic test_logic();
        int lat; logic [31:0] r; logic [2:0] zon;
        run_op(32'd10, 32'hFFFF_FFDD, 5'd0, 6'b011000, 1'b0, lat, r, zon);
        n_checks++;
        if ({r, zon, lat[7:0]} !== {32'h0000_0008, 3'b000, 8'd1})
            $display("FAIL and got res=%h zon=%b lat=%0d exp 00000008 000 1", r, zon, lat);
        else n_pass++;
        run_op(32'd10, 32'hFFFF_FFDD, 5'd0, 6'b011110, 1'b0, lat, r, zon);
        n_checks++;
        if ({r, zon} !== {32'hFFFF_FFDF, 3'b001})
            $display("FAIL or got res=%h zon=%b exp ffffffdf 001", r, zon);
        else n_pass++;
        run_op(32'd10, 32'hFFFF_FFDD, 5'd0, 6'b010001, 1'b0, lat, r, zon);
        n_checks++;
        if ({r, zon} !== {32'h0000_0020, 3'b000})
            $display("FAIL nor got res=%h zon=%b exp 00000020 000", r, zon);
        else n_pass++;
        run_op(32'd10, 32'hFFFF_FFDD, 5'd0, 6'b010110, 1'b0, lat, r, zon);
        n_checks++;
        if ({r, zon} !== {32'hFFFF_FFD7, 3'b001})
            $display("FAIL xor got res=%h zon=%b exp ffffffd7 001", r, zon);
        else n_pass++;
        run_op(32'd0, 32'hFFFF_FFDD, 5'd0, 6'b011010, 1'b0, lat, r, zon);
        n_checks++;
        if ({r, zon} !== {32'h0000_0000, 3'b100})
            $display("FAIL pass_a got res=%h zon=%b exp 00000000 100", r, zon);
        else n_pass++;
    endtask

    task automatic test_shift();
        int lat; logic [31:0] r; logic [2:0] zon;
        run_op(32'd0, 32'hFFFF_FFDD, 5'd22, 6'b100000, 1'b0, lat, r, zon);
        n_checks++;
        if ({r, zon, lat[7:0]} !== {32'hF740_0000, 3'b001, 8'd23})
            $display("FAIL sll22 got res=%h zon=%b lat=%0d exp f7400000 001 23", r, zon, lat);
        else n_pass++;
        run_op(32'd0, 32'hFFFF_FFDD, 5'd3, 6'b100001, 1'b0, lat, r, zon);
        n_checks++;
        if ({r, zon, lat[7:0]} !== {32'h1FFF_FFFB, 3'b000, 8'd4})
            $display("FAIL srl3 got res=%h zon=%b lat=%0d exp 1ffffffb 000 4", r, zon, lat);
        else n_pass++;
        run_op(32'd0, 32'hFFFF_FFDD, 5'd3, 6'b100011, 1'b0, lat, r, zon);
        n_checks++;
        if ({r, zon, lat[7:0]} !== {32'hFFFF_FFFB, 3'b001, 8'd4})
            $display("FAIL sra3 got res=%h zon=%b lat=%0d exp fffffffb 001 4", r, zon, lat);
        else n_pass++;
        run_op(32'd0, 32'hFFFF_FFDD, 5'd0, 6'b100000, 1'b0, lat, r, zon);
        n_checks++;
        if ({r, lat[7:0]} !== {32'hFFFF_FFDD, 8'd1})
            $display("FAIL shift0 got res=%h lat=%0d exp ffffffdd 1", r, lat);
        else n_pass++;
    endtask

    task automatic test_arith();
        int lat; logic [31:0] r; logic [2:0] zon;
        run_op(32'hFFFF_FFFF, 32'd1, 5'd0, 6'b000001, 1'b0, lat, r, zon);
        n_checks++;
        if ({r, zon, lat[7:0]} !== {32'hFFFF_FFFE, 3'b000, 8'd1})
            $display("FAIL sub_unsigned got res=%h zon=%b lat=%0d exp fffffffe 000 1", r, zon, lat);
        else n_pass++;
        run_op(32'hFFFF_FFFF, 32'd1, 5'd0, 6'b000000, 1'b0, lat, r, zon);
        n_checks++;
        if ({r, zon} !== {32'h0000_0000, 3'b110})
            $display("FAIL add_carry got res=%h zon=%b exp 00000000 110", r, zon);
        else n_pass++;
        run_op(32'h7FFF_FFFF, 32'd1, 5'd0, 6'b000000, 1'b1, lat, r, zon);
        n_checks++;
        if ({r, zon} !== {32'h8000_0000, 3'b010})
            $display("FAIL add_signed_ovf got res=%h zon=%b exp 80000000 010", r, zon);
        else n_pass++;
        run_op(32'd1, 32'd2, 5'd0, 6'b000001, 1'b0, lat, r, zon);
        n_checks++;
        if ({r, zon} !== {32'hFFFF_FFFF, 3'b011})
            $display("FAIL sub_borrow got res=%h zon=%b exp ffffffff 011", r, zon);
        else n_pass++;
    endtask

    task automatic test_compare();
        int lat; logic [31:0] r; logic [2:0] zon;
        run_op(32'hFFFF_FFFF, 32'd1, 5'd0, 6'b110101, 1'b1, lat, r, zon);
        n_checks++;
        if ({r, zon} !== {32'd1, 3'b000}) $display("FAIL lt_signed got res=%h zon=%b exp 00000001 000", r, zon);
        else n_pass++;
        run_op(32'hFFFF_FFFF, 32'd1, 5'd0, 6'b110101, 1'b0, lat, r, zon);
        n_checks++;
        if ({r, zon} !== {32'd0, 3'b100}) $display("FAIL lt_unsigned got res=%h zon=%b exp 00000000 100", r, zon);
        else n_pass++;
        run_op(32'd0, 32'd5, 5'd0, 6'b111111, 1'b0, lat, r, zon);
        n_checks++;
        if (r !== 32'd0) $display("FAIL gtz_zero got %h exp 00000000", r);
        else n_pass++;
        run_op(32'd0, 32'd5, 5'd0, 6'b111101, 1'b0, lat, r, zon);
        n_checks++;
        if (r !== 32'd1) $display("FAIL lez_zero got %h exp 00000001", r);
        else n_pass++;
        run_op(32'h8000_0000, 32'd0, 5'd0, 6'b111001, 1'b0, lat, r, zon);
        n_checks++;
        if (r !== 32'd0) $display("FAIL gez_neg got %h exp 00000000", r);
        else n_pass++;
        run_op(32'h1234_5678, 32'h1234_5678, 5'd0, 6'b110011, 1'b0, lat, r, zon);
        n_checks++;
        if (r !== 32'd1) $display("FAIL eq got %h exp 00000001", r);
        else n_pass++;
        run_op(32'h1234_5678, 32'h1234_5678, 5'd0, 6'b110001, 1'b0, lat, r, zon);
        n_checks++;
        if (r !== 32'd0) $display("FAIL neq got %h exp 00000000", r);
        else n_pass++;
    endtask

    task automatic test_undefined();
        int lat; logic [31:0] r; logic [2:0] zon;
        run_op(32'hDEAD_BEEF, 32'h1, 5'd7, 6'b001111, 1'b1, lat, r, zon);
        n_checks++;
        if ({r, zon, lat[7:0]} !== {32'd0, 3'b100, 8'd1})
            $display("FAIL undefined got res=%h zon=%b lat=%0d exp 00000000 100 1", r, zon, lat);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int bad;
        @(negedge clk);
        bus.A = 32'd5; bus.B = 32'd7; bus.shamt = 5'd0; bus.ALUFunc = 6'b000001; bus.Signed = 1'b1;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.A = 32'd1; bus.B = 32'd2; bus.ALUFunc = 6'b000000; bus.Signed = 1'b0;
        n_checks++;
        if ({bus.resp_valid, bus.Result, bus.Zero, bus.Overflow, bus.Negative} !== {1'b1, 32'hFFFF_FFFE, 3'b001})
            $display("FAIL bp_first got vld=%b res=%h exp 1 fffffffe flags 001", bus.resp_valid, bus.Result);
        else n_pass++;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if ({bus.req_ready, bus.resp_valid, bus.Result, bus.Zero, bus.Overflow, bus.Negative}
                !== {2'b01, 32'hFFFF_FFFE, 3'b001}) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL bp_hold got %0d unstable cycles exp 0", bad);
        else n_pass++;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        n_checks++;
        if ({bus.resp_valid, bus.req_ready} !== 2'b01)
            $display("FAIL bp_after_hs got vld/rdy=%b%b exp 01", bus.resp_valid, bus.req_ready);
        else n_pass++;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_checks++;
        if ({bus.resp_valid, bus.Result, bus.Zero, bus.Overflow, bus.Negative} !== {1'b1, 32'd3, 3'b000})
            $display("FAIL bp_pending got vld=%b res=%h exp 1 00000003", bus.resp_valid, bus.Result);
        else n_pass++;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_operand_isolation();
        int lat;
        @(negedge clk);
        bus.A = 32'd0; bus.B = 32'hF0F0_F0F0; bus.shamt = 5'd4; bus.ALUFunc = 6'b100001; bus.Signed = 1'b0;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.A = 32'hFFFF_FFFF; bus.B = 32'd0; bus.shamt = 5'd31; bus.ALUFunc = 6'b100000; bus.Signed = 1'b1;
        lat = 1;
        while (!bus.resp_valid && lat < 100) begin @(negedge clk); lat++; end
        n_checks++;
        if ({bus.Result, lat[7:0]} !== {32'h0F0F_0F0F, 8'd5})
            $display("FAIL shift_isolation got res=%h lat=%0d exp 0f0f0f0f 5", bus.Result, lat);
        else n_pass++;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        int seen; int lat; logic [31:0] r; logic [2:0] zon;
        @(negedge clk);
        bus.A = 32'd0; bus.B = 32'h0000_0001; bus.shamt = 5'd20; bus.ALUFunc = 6'b100000; bus.Signed = 1'b0;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.req_ready, bus.resp_valid, bus.Result, bus.Zero, bus.Overflow, bus.Negative} !== 37'd0)
            $display("FAIL mid_reset_outputs got rdy=%b vld=%b res=%h exp all 0",
                     bus.req_ready, bus.resp_valid, bus.Result);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL mid_reset_no_resp got %0d valid cycles exp 0", seen);
        else n_pass++;
        run_op(32'd3, 32'd4, 5'd0, 6'b000000, 1'b0, lat, r, zon);
        n_checks++;
        if ({r, zon, lat[7:0]} !== {32'd7, 3'b000, 8'd1})
            $display("FAIL post_reset_add got res=%h zon=%b lat=%0d exp 00000007 000 1", r, zon, lat);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
        bus.A = 32'd0; bus.B = 32'd0; bus.shamt = 5'd0; bus.ALUFunc = 6'd0; bus.Signed = 1'b0;
        test_reset();
        test_logic();
        test_shift();
        test_arith();
        test_compare();
        test_undefined();
        test_backpressure();
        test_operand_isolation();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_serial_unit.md
# alu_serial_unit

Sequential ALU execution unit for the MIPS datapath. It accepts one ALU operation per request over a valid/ready handshake and returns the result with Zero/Overflow/Negative flags over a second valid/ready handshake. It uses the same ALUFunc encoding as the combinational Arith/Logic/Shift blocks. Shifts run bit-serially, one position per cycle, so a single-bit shifter replaces the barrel shifter. Upstream is the issue stage; downstream is writeback/branch resolution.

## Interface
- No parameters; data width fixed at 32, shift amount fixed at 5 bits.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- A  in  32  operand A
- B  in  32  operand B (shift source)
- shamt  in  5  shift amount
- ALUFunc  in  6  operation code
- Signed  in  1  1 = two's-complement arithmetic/compare
- resp_valid  out  1  result present
- resp_ready  in  1  consumer takes result
- Result  out  32  operation result
- Zero  out  1  Result == 0
- Overflow  out  1  arithmetic overflow
- Negative  out  1  arithmetic result below zero

## Operation
- Opcodes:
  - ADD 000000, SUB 000001.
  - AND 011000, OR 011110, XOR 010110, NOR 010001, A (pass A) 011010.
  - SLL 100000, SRL 100001, SRA 100011.
  - EQ 110011, NEQ 110001, LT 110101, LEZ 111101, GEZ 111001, GTZ 111111.
- Request accepted when req_valid && req_ready. A, B, shamt, ALUFunc and Signed are captured only at accept; later input changes are ignored.
- FSM: IDLE -> (accept, non-shift) DONE; IDLE -> (accept, shift) SHIFT; SHIFT -> DONE when the remaining count reaches 0; DONE -> IDLE on resp_valid && resp_ready.
- SHIFT state:
  - The working register loads B and the counter loads shamt.
  - Each cycle with count > 0, shift one position and decrement the counter.
  - SLL fills 0. SRL fills 0. SRA fills the captured B[31].
- Arithmetic: 32-bit modular sum/difference.
  - Signed=1: Overflow = two's-complement overflow; Negative = Result[31] XOR Overflow (sign of the exact result).
  - Signed=0: ADD gives Overflow = carry-out and Negative = 0. SUB gives Overflow = borrow and Negative = borrow.
- Compares: Result = {31'b0, cond}.
  - EQ/NEQ compare A with B.
  - LT uses signed or unsigned ordering per Signed.
  - LEZ/GEZ/GTZ compare A against 0, always signed.
- Logic, shift and compare ops: Overflow = 0, Negative = Result[31].
- All ops: Zero = (Result == 0).
- Undefined ALUFunc: Result 0, Zero 1, Overflow 0, Negative 0; completes in 1 cycle.

## Timing
- Reset values: req_ready 0 while reset low, 1 in the first cycle after release. resp_valid 0; Result 0; Zero 0; Overflow 0; Negative 0. State = IDLE.
- Non-shift latency: resp_valid rises the cycle after accept (1 cycle).
- Shift latency: shamt + 1 cycles from accept to resp_valid. shamt = 0 gives 1 cycle with Result = B.
- Result and flags are registered. They are stable for the whole time resp_valid is high and change only after the response handshake.
- Backpressure: while resp_valid && !resp_ready, hold all outputs. req_ready stays 0.
- Throughput: req_ready returns to 1 the cycle after the response handshake. No accept occurs in the same cycle as a response handshake.
- Reset asserted mid-SHIFT or mid-DONE: immediately (asynchronously) return to IDLE and clear all outputs. The pending operation is discarded and no response is produced.
- req_valid held high while busy: the request is not accepted. It stays pending until req_ready is 1.

## Test plan
- A=10, B=0xFFFFFFDD, AND -> Result 0x00000008, Zero 0, 1-cycle latency. Same operands with OR -> 0xFFFFFFDF, Negative 1. NOR -> 0x00000020.
- B=0xFFFFFFDD, shamt=22, SLL -> Result 0xF7400000 after 23 cycles. shamt=3 SRL -> 0x1FFFFFFB after 4 cycles. shamt=3 SRA -> 0xFFFFFFFB. shamt=0 -> 0xFFFFFFDD after 1 cycle.
- Arithmetic:
  - Signed=0, A=0xFFFFFFFF, B=1, SUB -> 0xFFFFFFFE, Overflow 0, Zero 0, Negative 0.
  - Same operands, ADD -> 0x00000000, Overflow 1, Zero 1.
  - Signed=1, A=0x7FFFFFFF, B=1, ADD -> 0x80000000, Overflow 1, Negative 0.
- Compares:
  - LT with A=0xFFFFFFFF, B=1 -> Result 1 when Signed=1, 0 when Signed=0.
  - GTZ with A=0 -> 0. LEZ with A=0 -> 1.
- Backpressure: hold resp_ready low 5 cycles after resp_valid -> Result and flags stay constant, req_ready stays 0. Change A/B during SHIFT -> the result is unaffected.
- Reset: drive reset low at cycle 10 of a shamt=20 shift -> outputs 0, no resp_valid afterwards. After release, a new ADD request completes normally.
